// File: rtl/wb_arbiter_scoreboard_pkg.sv
// Shared types and constants for the register-file write-back path.
package wb_arbiter_scoreboard_pkg;

  localparam int unsigned XLEN_W    = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned NREG      = 32;

  localparam int unsigned WB_SRC_ALU = 0;
  localparam int unsigned WB_SRC_LSU = 1;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN_W-1:0]    data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_scoreboard_if.sv
// Result-source handshakes, decode hazard queries and the register-file write port.
interface wb_arbiter_scoreboard_if
  import wb_arbiter_scoreboard_pkg::*;
#(
  parameter int unsigned NSRC = 2,
  parameter int unsigned XLEN = XLEN_W
);

  logic [NSRC-1:0]           src_valid;
  logic [NSRC-1:0]           src_ready;
  logic [NSRC*REG_IDX_W-1:0] src_rd;
  logic [NSRC*XLEN-1:0]      src_data;
  logic                      issue_en;
  logic [REG_IDX_W-1:0]      issue_rd;
  logic [REG_IDX_W-1:0]      rs1_idx;
  logic [REG_IDX_W-1:0]      rs2_idx;
  logic                      rs1_busy;
  logic                      rs2_busy;
  logic                      rd_busy;
  logic                      wreg_en;
  logic [REG_IDX_W-1:0]      wreg_index;
  logic [XLEN-1:0]           wdata;

  modport master (
    output src_valid, src_rd, src_data, issue_en, issue_rd, rs1_idx, rs2_idx,
    input  src_ready, rs1_busy, rs2_busy, rd_busy, wreg_en, wreg_index, wdata
  );

  modport slave (
    input  src_valid, src_rd, src_data, issue_en, issue_rd, rs1_idx, rs2_idx,
    output src_ready, rs1_busy, rs2_busy, rd_busy, wreg_en, wreg_index, wdata
  );

endinterface

// File: rtl/wb_arbiter_scoreboard_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last winner.
module rr_arbiter #(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int unsigned IdxW = (N > 1) ? $clog2(N) : 1;

  logic [IdxW-1:0] last_q;
  logic            found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    // Scan offsets 1..N from the last winner; offset N revisits the last winner itself.
    for (int unsigned off = 1; off <= N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && req[i] && (((32'(last_q) + off) % N) == i)) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= IdxW'(N - 1);
    end else if (advance) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (gnt[i]) last_q <= IdxW'(i);
      end
    end
  end

endmodule

// File: rtl/wb_arbiter_scoreboard.sv
// Write-back arbiter onto the single register-file write port, plus the RAW/WAW
// pending scoreboard consulted by decode.
module wb_arbiter_scoreboard
  import wb_arbiter_scoreboard_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_W,
  parameter int unsigned NREG = 32,
  parameter int unsigned NSRC = 2
) (
  input logic                     clk,
  input logic                     reset,
  wb_arbiter_scoreboard_if.slave  bus
);

  logic [NSRC-1:0]      gnt;
  logic [NSRC-1:0]      ready;
  logic                 accept;
  wb_req_t              sel;
  logic                 wreg_en_q;
  logic [REG_IDX_W-1:0] wreg_index_q;
  logic [XLEN-1:0]      wdata_q;
  logic [NREG-1:0]      pending_q, pending_d;

  rr_arbiter #(.N(NSRC)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (bus.src_valid),
    .advance (accept),
    .gnt     (gnt)
  );

  assign ready         = gnt & {NSRC{~reset}};
  assign accept        = |ready;
  assign bus.src_ready = ready;

  always_comb begin
    sel = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (gnt[i]) begin
        sel.rd   = bus.src_rd[i*REG_IDX_W +: REG_IDX_W];
        sel.data = bus.src_data[i*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wreg_en_q    <= 1'b0;
      wreg_index_q <= '0;
      wdata_q      <= '0;
    end else if (accept) begin
      // x0 results complete the handshake but never reach the register file.
      wreg_en_q    <= (sel.rd != '0);
      wreg_index_q <= sel.rd;
      wdata_q      <= sel.data;
    end else begin
      wreg_en_q    <= 1'b0;
    end
  end

  assign bus.wreg_en    = wreg_en_q;
  assign bus.wreg_index = wreg_index_q;
  assign bus.wdata      = wdata_q;

  // Set after clear: an issuing producer is younger than the committing one.
  always_comb begin
    pending_d = pending_q;
    if (wreg_en_q) pending_d[wreg_index_q] = 1'b0;
    if (bus.issue_en && (bus.issue_rd != '0)) pending_d[bus.issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending_q <= '0;
    else       pending_q <= pending_d;
  end

  // Same-cycle writes are bypassed by the register file, so they do not stall.
  assign bus.rs1_busy = pending_q[bus.rs1_idx] &
                        ~(wreg_en_q & (wreg_index_q == bus.rs1_idx));
  assign bus.rs2_busy = pending_q[bus.rs2_idx] &
                        ~(wreg_en_q & (wreg_index_q == bus.rs2_idx));
  assign bus.rd_busy  = pending_q[bus.issue_rd] &
                        ~(wreg_en_q & (wreg_index_q == bus.issue_rd));

endmodule

// File: tb/tb_wb_arbiter_scoreboard.sv
// Directed bench for wb_arbiter_scoreboard: vector table plus reset sequences.
module tb_wb_arbiter_scoreboard;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  wb_arbiter_scoreboard_if #(.NSRC(2), .XLEN(32)) bus ();

  wb_arbiter_scoreboard #(.XLEN(32), .NREG(32), .NSRC(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  valid;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        issue_en;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [1:0]  ready;
    logic        rs1_b;
    logic        rs2_b;
    logic        rd_b;
    logic        wen;
    logic [4:0]  widx;
    logic [31:0] wdata;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [1:0] valid, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic [4:0] rd1, input logic [31:0] d1, input logic ien,
                       input logic [4:0] ird, input logic [4:0] rs1, input logic [4:0] rs2);
    bus.src_valid = valid;
    bus.src_rd    = {rd1, rd0};
    bus.src_data  = {d1, d0};
    bus.issue_en  = ien;
    bus.issue_rd  = ird;
    bus.rs1_idx   = rs1;
    bus.rs2_idx   = rs2;
  endtask

  // Decode must never issue onto a register whose write is still outstanding.
  always @(negedge clk) begin
    if (!reset && bus.issue_en) begin
      checks++;
      if (bus.rd_busy) begin
        errors++;
        $display("FAIL issue_while_rd_busy: issue_rd=%0d rd_busy=1", bus.issue_rd);
      end
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    //                valid rd0 d0            rd1 d1            ien ird rs1 rs2
    //                ready r1b r2b rdb wen widx wdata
    vecs[0]  = '{2'b11, 5'd3, 32'hA000_0003, 5'd4, 32'hB000_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA000_0003};
    vecs[1]  = '{2'b11, 5'd3, 32'hA000_0003, 5'd4, 32'hB000_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hB000_0004};
    vecs[2]  = '{2'b11, 5'd3, 32'hA000_0003, 5'd4, 32'hB000_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'hA000_0003};
    vecs[3]  = '{2'b11, 5'd3, 32'hA000_0003, 5'd4, 32'hB000_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 5'd4, 32'hB000_0004};
    vecs[4]  = '{2'b01, 5'd5, 32'hDEAD_BEEF, 5'd4, 32'hB000_0004, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF};
    vecs[5]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEAD_BEEF};
    vecs[6]  = '{2'b10, 5'd0, 32'h0, 5'd0, 32'h0000_1234, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_1234};
    vecs[7]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0,
                 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0000_1234};
    vecs[8]  = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0000_1234};
    vecs[9]  = '{2'b01, 5'd7, 32'h7777_7777, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0,
                 2'b01, 1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 32'h7777_7777};
    vecs[10] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h7777_7777};
    vecs[11] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd7,
                 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 32'h7777_7777};
    vecs[12] = '{2'b01, 5'd9, 32'h0000_0099, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0,
                 2'b01, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 32'h0000_0099};
    vecs[13] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd9, 5'd9, 5'd0,
                 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_0099};
    vecs[14] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd9, 5'd0,
                 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0099};
    vecs[15] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd9, 5'd0,
                 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_0099};
    vecs[16] = '{2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd9,
                 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h0000_0099};

    // Power-on reset with both sources requesting.
    reset = 1'b1;
    drive(2'b11, 5'd3, 32'h1, 5'd4, 32'h2, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    chk("reset_src_ready", 32'(bus.src_ready), 32'h0);
    chk("reset_wreg_en", 32'(bus.wreg_en), 32'h0);
    chk("reset_wreg_index", 32'(bus.wreg_index), 32'h0);
    chk("reset_wdata", bus.wdata, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    for (int v = 0; v < NVEC; v++) begin
      drive(vecs[v].valid, vecs[v].rd0, vecs[v].d0, vecs[v].rd1, vecs[v].d1,
            vecs[v].issue_en, vecs[v].issue_rd, vecs[v].rs1, vecs[v].rs2);
      #3;
      chk($sformatf("v%0d_src_ready", v), 32'(bus.src_ready), 32'(vecs[v].ready));
      chk($sformatf("v%0d_rs1_busy", v), 32'(bus.rs1_busy), 32'(vecs[v].rs1_b));
      chk($sformatf("v%0d_rs2_busy", v), 32'(bus.rs2_busy), 32'(vecs[v].rs2_b));
      chk($sformatf("v%0d_rd_busy", v), 32'(bus.rd_busy), 32'(vecs[v].rd_b));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wreg_en", v), 32'(bus.wreg_en), 32'(vecs[v].wen));
      chk($sformatf("v%0d_wreg_index", v), 32'(bus.wreg_index), 32'(vecs[v].widx));
      chk($sformatf("v%0d_wdata", v), bus.wdata, vecs[v].wdata);
    end

    // Fill pending[1..4], then commit a write so the output stage is live.
    for (int r = 1; r <= 4; r++) begin
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b1, 5'(r), 5'd0, 5'd0);
      @(posedge clk);
      #1;
    end
    drive(2'b01, 5'd5, 32'h5555_5555, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1, 5'd4);
    #3;
    chk("pre_rst_rs1_busy", 32'(bus.rs1_busy), 32'h1);
    chk("pre_rst_rs2_busy", 32'(bus.rs2_busy), 32'h1);
    @(posedge clk);
    #1;
    chk("pre_rst_wreg_en", 32'(bus.wreg_en), 32'h1);
    drive(2'b11, 5'd3, 32'hC000_0003, 5'd4, 32'hD000_0004, 1'b0, 5'd0, 5'd0, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_wreg_en", 32'(bus.wreg_en), 32'h0);
    chk("async_rst_wreg_index", 32'(bus.wreg_index), 32'h0);
    chk("async_rst_wdata", bus.wdata, 32'h0);
    chk("async_rst_src_ready", 32'(bus.src_ready), 32'h0);
    for (int r = 1; r <= 4; r++) begin
      bus.rs1_idx = 5'(r);
      #1;
      chk($sformatf("async_rst_rs1_busy_x%0d", r), 32'(bus.rs1_busy), 32'h0);
    end
    bus.rs1_idx = 5'd0;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("post_rst_grant", 32'(bus.src_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("post_rst_wreg_index", 32'(bus.wreg_index), 32'h3);
    chk("post_rst_wdata", bus.wdata, 32'hC000_0003);
    drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    @(posedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_scoreboard.md
Name: wb_arbiter_scoreboard

Overview:
- Write side of the integer register file. Collects results from up to NSRC functional units (slot 0 = ALU, slot 1 = LSU/MDU) through valid/ready handshakes.
- Arbitrates them round-robin onto the single register-file write port (wreg_en/wdata/wreg_index).
- Keeps a per-register pending scoreboard that decode uses to stall on RAW hazards against in-flight producers.

Parameters:
- XLEN, 32, data width
- NREG, 32, number of architectural registers; index width is $clog2(NREG)
- NSRC, 2, number of result sources, 2..4

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- src_valid  input  NSRC  result valid, one bit per source
- src_ready  output  NSRC  result accepted, one bit per source
- src_rd  input  NSRC*5  destination register index per source
- src_data  input  NSRC*XLEN  result data per source
- issue_en  input  1  an instruction with a destination register issues this cycle
- issue_rd  input  5  destination register of the issuing instruction
- rs1_idx  input  5  decode source 1 index
- rs2_idx  input  5  decode source 2 index
- rs1_busy  output  1  source 1 has an outstanding producer
- rs2_busy  output  1  source 2 has an outstanding producer
- rd_busy  output  1  issue_rd already pending (WAW stall)
- wreg_en  output  1  register-file write enable
- wreg_index  output  5  register-file write address
- wdata  output  XLEN  register-file write data

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - wreg_en=0, wreg_index=0, wdata=0.
  - pending[NREG-1:0]=0.
  - last_grant pointer = NSRC-1, so source 0 wins first.
  - src_ready=0 while reset is asserted.
  - Reset mid-operation discards the output stage and every pending bit.
- Arbitration, combinational:
  - Grant goes to the first valid source after last_grant, cyclically.
  - src_ready = one-hot grant. At most one source is accepted per cycle.
  - No grant when no source is valid.
  - src_ready must not depend on the granted source's src_rd or src_data.
  - A source holds src_valid, src_rd and src_data stable until it sees ready.
- last_grant updates only on an accepted transfer.
- Output stage is a register; the register file always accepts, so the stage never stalls. Latency is exactly 1 cycle from accept.
- On accept:
  - wreg_en <= (src_rd != 0); wreg_index <= src_rd; wdata <= src_data.
  - A write to x0 is accepted and handshaked but not presented (wreg_en=0).
- With no accept, wreg_en <= 0 and wreg_index/wdata hold their values.
- Scoreboard, updated per cycle:
  - clear pending[wreg_index] when wreg_en=1.
  - set pending[issue_rd] when issue_en=1 and issue_rd != 0.
  - set and clear on the same index in the same cycle: set wins, because the new producer is younger.
  - pending[0] is constant 0.
- Busy outputs, combinational:
  - rsN_busy = pending[rsN_idx] & ~(wreg_en & wreg_index==rsN_idx). The register file bypasses same-cycle writes, so the committing value is readable without a stall.
  - rd_busy uses the same form on issue_rd.
  - rs index 0 always gives busy=0.
- Issuing to a register whose rd_busy=1 is illegal; decode must stall. The bench asserts issue_en & rd_busy never occurs.
- A src_valid for a register that is not pending is legal, e.g. a replay with no scoreboard entry. The clear is then a no-op.

Decomposition:
- Shared package gets:
  - XLEN_W, REG_IDX_W=5, NREG.
  - Source-slot constants WB_SRC_ALU=0 and WB_SRC_LSU=1.
  - A wb_req_t struct {rd, data}.
- One natural sub-module: rr_arbiter, parameterised on N. Inputs req[N] and an advance strobe; outputs a one-hot grant and holds the last_grant pointer.
- Scoreboard and output register stay in the top module.

Test Plan:
- ALU only: src_valid=01, rd=5, data=0xDEADBEEF at cycle 0 -> src_ready=01 at cycle 0; wreg_en=1, wreg_index=5, wdata=0xDEADBEEF at cycle 1; wreg_en=0 at cycle 2.
- Contention: both valid for 4 cycles with rd 3 and 4 after reset -> grants 0,1,0,1; writes rd 3,4,3,4 appear at cycles 1..4.
- x0 drop: source 1 valid, rd=0, data=0x1234 -> src_ready=10 the same cycle; wreg_en stays 0 next cycle; no pending bit changes.
- Hazard and bypass: issue_en with rd=7, then rs1_idx=7 -> rs1_busy=1; ALU result rd=7 accepted at cycle N -> rs1_busy=0 at cycle N+1 (bypass window) and afterwards.
- Same-cycle set/clear: wreg_en with index 9 while issue_en with rd=9 -> pending[9]=1 next cycle; rd_busy=1 for rd 9.
- Async reset: assert reset mid-cycle with pending[1..4] set and wreg_en=1 -> all outputs and pending clear immediately, without waiting for a clock edge; after release, first contention grant goes to source 0.
